// File: rtl/ub_readback_streamer.sv
// Unified Buffer readback: reads row_count rows starting at base_addr and streams each row LSB byte first.
// Optional feature macro UB_READBACK_CHECKSUM_EN appends an XOR checksum byte after the last data byte.
module ub_readback_streamer #(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 8,
   parameter int CNT_W      = 9,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  row_count,
   input  logic              abort,
   output logic              ub_rd_en,
   output logic [ADDR_W-1:0] ub_rd_addr,
   input  logic [DATA_W-1:0] ub_rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic [15:0]       bytes_sent
);
   localparam int NBYTES = DATA_W / 8;
   localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
   localparam logic [1:0]        LAT_LAST  = 2'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_SEND    = 3'd3,
`ifdef UB_READBACK_CHECKSUM_EN
      ST_CSUM    = 3'd4,
`endif
      ST_FIN     = 3'd5
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_en_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  row_idx_q;
   logic [BIDX_W-1:0] byte_idx_q;
   logic [1:0]        wait_q;
   logic [DATA_W-1:0] shift_q;
   logic              tx_valid_q;
   logic              busy_q;
   logic              done_q;
   logic [15:0]       bytes_sent_q;
   logic [15:0]       bytes_sent_d;
   logic              hs;
   logic              more_rows;
`ifdef UB_READBACK_CHECKSUM_EN
   logic [7:0]        csum_q;
   logic [7:0]        csum_d;

   assign csum_d = csum_q ^ shift_q[7:0];
`endif

   // A byte counts as sent on every valid/ready edge, abort or not.
   assign hs           = tx_valid_q & tx_ready;
   assign bytes_sent_d = (hs && (bytes_sent_q != 16'hFFFF)) ? bytes_sent_q + 16'd1 : bytes_sent_q;
   assign more_rows    = (row_idx_q + CNT_W'(1)) < count_q;

   assign ub_rd_en   = rd_en_q;
   assign ub_rd_addr = rd_addr_q;
   assign tx_data    = shift_q[7:0];
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign bytes_sent = bytes_sent_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rd_addr_q    <= '0;
         rd_en_q      <= 1'b0;
         count_q      <= '0;
         row_idx_q    <= '0;
         byte_idx_q   <= '0;
         wait_q       <= '0;
         shift_q      <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         bytes_sent_q <= '0;
`ifdef UB_READBACK_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         rd_en_q      <= 1'b0;
         done_q       <= 1'b0;
         bytes_sent_q <= bytes_sent_d;
         if (abort && (state_q != ST_IDLE)) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     rd_addr_q    <= base_addr;
                     count_q      <= row_count;
                     row_idx_q    <= '0;
                     byte_idx_q   <= '0;
                     bytes_sent_q <= '0;
`ifdef UB_READBACK_CHECKSUM_EN
                     csum_q       <= '0;
`endif
                     if (row_count == '0) begin
`ifdef UB_READBACK_CHECKSUM_EN
                        state_q    <= ST_CSUM;
                        busy_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        shift_q    <= '0;
`else
                        state_q    <= ST_FIN;
                        done_q     <= 1'b1;
`endif
                     end else begin
                        state_q <= ST_RD_REQ;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                     end
                  end
               end
               ST_RD_REQ: begin
                  state_q <= ST_RD_WAIT;
                  wait_q  <= '0;
               end
               ST_RD_WAIT: begin
                  if (wait_q == LAT_LAST) begin
                     shift_q    <= ub_rd_data;
                     tx_valid_q <= 1'b1;
                     byte_idx_q <= '0;
                     state_q    <= ST_SEND;
                  end else begin
                     wait_q <= wait_q + 2'd1;
                  end
               end
               ST_SEND: begin
                  if (hs) begin
                     shift_q    <= shift_q >> 8;
                     byte_idx_q <= byte_idx_q + BIDX_W'(1);
`ifdef UB_READBACK_CHECKSUM_EN
                     csum_q     <= csum_d;
`endif
                     if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_q <= '0;
                        if (more_rows) begin
                           // No prefetch: next row is requested only once this one has drained.
                           row_idx_q  <= row_idx_q + CNT_W'(1);
                           rd_addr_q  <= rd_addr_q + ADDR_W'(1);
                           rd_en_q    <= 1'b1;
                           tx_valid_q <= 1'b0;
                           state_q    <= ST_RD_REQ;
                        end else begin
`ifdef UB_READBACK_CHECKSUM_EN
                           shift_q    <= DATA_W'(csum_d);
                           state_q    <= ST_CSUM;
`else
                           tx_valid_q <= 1'b0;
                           busy_q     <= 1'b0;
                           done_q     <= 1'b1;
                           state_q    <= ST_FIN;
`endif
                        end
                     end
                  end
               end
`ifdef UB_READBACK_CHECKSUM_EN
               ST_CSUM: begin
                  if (hs) begin
                     tx_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= ST_FIN;
                  end
               end
`endif
               ST_FIN: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ub_readback_streamer.sv
// Bench for ub_readback_streamer: directed scenarios plus random transfers checked against a queue-based model.
// The expected byte stream is derived directly from the UB contents, row by row, LSB byte first.
module tb_ub_readback_streamer;
   localparam int DATA_W = 256;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 9;
   localparam int RD_LAT = 1;
   localparam int NB     = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  row_count;
   logic              abort;
   logic              ub_rd_en;
   logic [ADDR_W-1:0] ub_rd_addr;
   logic [DATA_W-1:0] ub_rd_data;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic              done;
   logic [15:0]       bytes_sent;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DATA_W-1:0] ub_mem [256];
   logic [7:0]        exp_bytes [$];
   logic [7:0]        exp_addr  [$];
   logic [7:0]        obs_bytes [$];
   logic [7:0]        obs_addr  [$];
   int                hs_cyc    [$];
   int                done_cnt;
   int                done_cyc;
   int                first_valid_cyc;
   int                start_cyc;
   bit                valid_seen;
   bit                prev_stall = 1'b0;
   logic [7:0]        prev_data;

   ub_readback_streamer #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W),
      .RD_LATENCY (RD_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .row_count  (row_count),
      .abort      (abort),
      .ub_rd_en   (ub_rd_en),
      .ub_rd_addr (ub_rd_addr),
      .ub_rd_data (ub_rd_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done),
      .bytes_sent (bytes_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] rand_row();
      logic [DATA_W-1:0] r;
      for (int w = 0; w < DATA_W / 32; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   // UB model with one-cycle registered read; junk otherwise so a mistimed capture is visible.
   always @(posedge clk) begin
      if (ub_rd_en) ub_rd_data <= ub_mem[ub_rd_addr];
      else          ub_rd_data <= rand_row();
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Passive monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ub_rd_en) obs_addr.push_back(ub_rd_addr);
         if (tx_valid) begin
            if (!valid_seen) first_valid_cyc = cyc;
            valid_seen = 1'b1;
         end
         if (tx_valid && tx_ready) begin
            obs_bytes.push_back(tx_data);
            hs_cyc.push_back(cyc);
         end
         if (prev_stall) begin
            chk("hold_valid", {31'd0, tx_valid}, 32'd1);
            chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
         end
         prev_stall = tx_valid && !tx_ready && !abort;
         prev_data  = tx_data;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", {31'd0, busy}, 32'd0);
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic void build_expect(input logic [7:0] base, input int cnt);
      logic [7:0] a;
      logic [7:0] v;
      logic [7:0] cs;
      exp_bytes.delete();
      exp_addr.delete();
      cs = 8'h00;
      for (int r = 0; r < cnt; r++) begin
         a = 8'((int'(base) + r) % 256);
         exp_addr.push_back(a);
         for (int b = 0; b < NB; b++) begin
            v = ub_mem[a][8*b +: 8];
            exp_bytes.push_back(v);
            cs = cs ^ v;
         end
      end
`ifdef UB_READBACK_CHECKSUM_EN
      exp_bytes.push_back(cs);
`endif
   endfunction

   task automatic clear_obs();
      obs_bytes.delete();
      obs_addr.delete();
      hs_cyc.delete();
      done_cnt        = 0;
      done_cyc        = -1;
      first_valid_cyc = -1;
      valid_seen      = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, {31'd0, ub_rd_en}, 32'd0);
      chk({tag, "_rd_addr"}, {24'd0, ub_rd_addr}, 32'd0);
      chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_bytes_sent"}, {16'd0, bytes_sent}, 32'd0);
   endtask

   task automatic start_xfer(input logic [7:0] base, input int cnt);
      build_expect(base, cnt);
      @(posedge clk); #1;
      clear_obs();
      base_addr = base;
      row_count = 9'(cnt);
      tx_ready  = 1'b1;
      start     = 1'b1;
      @(posedge clk); #1;
      start_cyc = cyc;
      start     = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      for (int c = 0; c < 400 && obs_bytes.size() < n; c++) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic run_xfer(input string name, input logic [7:0] base, input int cnt,
                           input bit rnd, input int inj_at);
      int budget;
      int n;
      bit injected;
      budget   = 200 + cnt * NB * 8;
      injected = 1'b0;
      start_xfer(base, cnt);
      for (int c = 0; c < budget && done_cnt == 0; c++) begin
         if (inj_at >= 0 && !injected && obs_bytes.size() >= inj_at) begin
            start     = 1'b1;
            base_addr = 8'($urandom);
            row_count = 9'($urandom_range(1, 5));
            injected  = 1'b1;
         end else begin
            start = 1'b0;
         end
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
      chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({name, "_valid_after"}, {31'd0, tx_valid}, 32'd0);
      chk({name, "_reads"}, obs_addr.size(), exp_addr.size());
      n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_addr%0d", name, i), {24'd0, obs_addr[i]}, {24'd0, exp_addr[i]});
      chk({name, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
      n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", name, i), {24'd0, obs_bytes[i]}, {24'd0, exp_bytes[i]});
      chk({name, "_bytes_sent"}, {16'd0, bytes_sent}, exp_bytes.size());
      chk({name, "_valid_seen"}, {31'd0, valid_seen}, {31'd0, exp_bytes.size() > 0});
      if (cnt > 0)
         chk({name, "_first_valid"}, first_valid_cyc, start_cyc + RD_LAT + 1);
      if (obs_bytes.size() > 0 && done_cnt == 1)
         chk({name, "_done_after_last"}, done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
      if (!rnd && cnt <= 1 && obs_bytes.size() > 0)
         chk({name, "_back_to_back"}, hs_cyc[hs_cyc.size()-1] - hs_cyc[0], obs_bytes.size() - 1);
      if (!rnd && obs_bytes.size() >= NB * cnt)
         for (int r = 1; r < cnt; r++)
            chk($sformatf("%s_gap%0d", name, r), hs_cyc[NB*r] - hs_cyc[NB*r-1], RD_LAT + 2);
      if (cnt == 0)
         chk({name, "_zero_done_latency"},
             {31'd0, (done_cyc >= start_cyc) && (done_cyc - start_cyc <= 2)}, 32'd1);
      $display("xfer %s: base=0x%02h rows=%0d bytes=%0d reads=%0d bytes_sent=%0d",
               name, base, cnt, obs_bytes.size(), obs_addr.size(), bytes_sent);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      tx_ready  = 1'b0;
      base_addr = '0;
      row_count = '0;
      clear_obs();
      for (int i = 0; i < 256; i++) ub_mem[i] = rand_row();
      for (int b = 0; b < NB; b++) ub_mem[8'h10][8*b +: 8] = 8'(b);

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero("post_reset");

      run_xfer("single_row", 8'h10, 1, 1'b0, -1);
      run_xfer("backpressure", 8'($urandom), 2, 1'b1, -1);
      run_xfer("wrap", 8'hFE, 3, 1'b0, -1);
      run_xfer("zero_count", 8'h33, 0, 1'b0, -1);

      // Abort right after the 5th byte of row 0, with no handshake on the abort edge.
      start_xfer(8'h40, 4);
      wait_bytes(5);
      chk("abort_reach5", obs_bytes.size(), 5);
      @(posedge clk); #1;
      abort    = 1'b1;
      tx_ready = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("abort_bytes_sent", {16'd0, bytes_sent}, 32'd5);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      chk("abort_reads", obs_addr.size(), 1);
      chk("abort_nbytes", obs_bytes.size(), 5);
      for (int i = 0; i < 5 && i < obs_bytes.size(); i++)
         chk($sformatf("abort_byte%0d", i), {24'd0, obs_bytes[i]}, {24'd0, exp_bytes[i]});
      $display("xfer abort: base=0x40 rows=4 bytes=%0d bytes_sent=%0d", obs_bytes.size(), bytes_sent);
      run_xfer("after_abort", 8'h41, 1, 1'b0, -1);

      // Abort on the same edge as a handshake: that byte still counts.
      start_xfer(8'h80, 2);
      wait_bytes(3);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_hs_bytes_sent", {16'd0, bytes_sent}, 32'd4);
      chk("abort_hs_busy", {31'd0, busy}, 32'd0);
      chk("abort_hs_tx_valid", {31'd0, tx_valid}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_hs_no_done", done_cnt, 0);
      $display("xfer abort_on_handshake: base=0x80 rows=2 bytes_sent=%0d", bytes_sent);

      run_xfer("start_while_busy", 8'($urandom), 3, 1'b1, 40);

      // Asynchronous reset in the middle of SEND.
      start_xfer(8'hC0, 2);
      wait_bytes(10);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("async_reset_no_done", done_cnt, 0);
      check_outputs_zero("after_reset_idle");
      $display("xfer async_reset: base=0xC0 rows=2 bytes_before_reset=%0d", obs_bytes.size());

      run_xfer("after_reset", 8'hC0, 2, 1'b1, -1);
      for (int t = 0; t < 4; t++)
         run_xfer($sformatf("random%0d", t), 8'($urandom), $urandom_range(1, 3), 1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ub_readback_streamer.md
Name: ub_readback_streamer

Overview:
- Readback path from the Unified Buffer to the host: the opposite direction of the UART programming path that writes UB rows.
- On a start command it reads N consecutive 256-bit UB rows and serializes each row into 32 bytes on a valid/ready byte stream.
- The byte stream feeds the UART TX framer.
- It sits between the UB read port mux and the UART transmitter, driven by the test interface's readback command decoder.

Parameters:
- DATA_W, 256, UB row width in bits; must be a multiple of 8.
- ADDR_W, 8, UB row address width.
- CNT_W, 9, width of the row-count field.
- RD_LATENCY, 1, cycles from ub_rd_en sample to ub_rd_data valid; legal range 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first UB row to read; sampled with start
- row_count  in  CNT_W  number of rows to read; sampled with start
- abort  in  1  synchronous cancel of the current transfer
- ub_rd_en  out  1  one-cycle UB read request
- ub_rd_addr  out  ADDR_W  UB row address for the request
- ub_rd_data  in  DATA_W  UB row data, valid RD_LATENCY cycles after the request
- tx_data  out  8  byte to the UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts the byte
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the transfer completes
- bytes_sent  out  16  bytes accepted in the current/last transfer; saturates at 0xFFFF

Behaviour:
- Reset values: all outputs 0, state IDLE, internal row/byte counters 0.
- States: IDLE, RD_REQ, RD_WAIT, SEND, CSUM (only when the feature is compiled in), FIN.
- IDLE:
  - start=1 latches base_addr and row_count, clears bytes_sent, moves to RD_REQ.
  - If row_count=0, moves to FIN instead (or to CSUM with the feature).
  - start is ignored in every non-IDLE state.
- RD_REQ: ub_rd_en=1 for exactly one cycle; ub_rd_addr = base_addr + row_index, modulo 2^ADDR_W (wraps 0xFF->0x00). Then RD_WAIT.
- RD_WAIT:
  - Counts RD_LATENCY cycles, then captures ub_rd_data into a DATA_W shift register and moves to SEND.
  - Timing: tx_valid first rises RD_LATENCY+1 clock edges after the edge that sampled start.
- SEND, byte order:
  - Byte 0 = row[7:0], sent first; byte 31 = row[255:248].
- SEND, handshake:
  - tx_valid is held high and tx_data held stable until tx_ready=1.
  - A transfer occurs on any edge with tx_valid & tx_ready; the next byte is presented the following cycle.
  - tx_ready may be high before tx_valid. tx_valid never depends combinationally on tx_ready.
- SEND, end of row:
  - After byte DATA_W/8-1 is accepted, go to RD_REQ if rows remain.
  - Otherwise go to FIN (or CSUM).
  - No prefetch: inter-row gap is RD_LATENCY+1 cycles with tx_valid=0.
- FIN: done=1 for one cycle; busy=0 in that same cycle; return to IDLE. A start in the FIN cycle is ignored.
- busy: 1 in RD_REQ, RD_WAIT, SEND and CSUM.
- bytes_sent: increments on every accepted byte, including the checksum byte; holds its value after done until the next start.
- abort, in any non-IDLE state:
  - Next cycle: state IDLE, tx_valid=0, busy=0, no done pulse.
  - If a byte handshake coincides with abort, that byte counts as sent.
  - If a read is outstanding, its returned data is discarded.
- Reset mid-transfer: everything returns immediately to reset values; no done pulse.
- ub_rd_en is never asserted outside RD_REQ. Exactly row_count reads are issued per completed transfer.

Optional Feature:
- Macro: UB_READBACK_CHECKSUM_EN.
- When defined:
  - Running XOR of every data byte, initialised to 0x00 at start.
  - After the last data byte is accepted, state CSUM presents the checksum as one extra byte under the same handshake, then FIN.
  - row_count=0 emits the single byte 0x00, then done.
- When undefined: no CSUM state, no checksum logic; the last data byte goes straight to FIN.

Test Plan:
- Single row: UB[0x10] = bytes 0x00..0x1F, start, base=0x10, count=1, tx_ready=1 -> one ub_rd_en with addr 0x10; tx_data sequence 0x00..0x1F on 32 consecutive cycles; done 1 cycle after the last byte; bytes_sent=32 (33 with checksum, checksum byte 0x00).
- Backpressure: count=2, tx_ready toggles 1/0 pseudo-randomly -> tx_data is stable while tx_valid&!tx_ready; 64 bytes in order; exactly 2 reads (addrs base, base+1).
- Wrap: base=0xFE, count=3 -> read addresses 0xFE, 0xFF, 0x00; bytes_sent=96.
- Zero count: start, count=0 -> no ub_rd_en, no tx_valid (one 0x00 byte with checksum), done pulse within 2 cycles.
- Abort and restart: abort after the 5th byte of row 0 of a count=4 transfer -> next cycle busy=0, tx_valid=0, no done, bytes_sent=5; a following start with count=1 runs normally.
- Start while busy, plus async reset: start pulse mid-transfer is ignored (read count unchanged); rst_n low mid-SEND -> all outputs 0 immediately.
